// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and the loader state type, shared by the loader and the control unit's decoder.
package rv_isa_pkg;

    typedef enum logic [1:0] {
        OP_ADDI = 2'b00,
        OP_BNE  = 2'b01,
        OP_SW   = 2'b10,
        OP_LW   = 2'b11
    } op_kind_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_LOAD = 2'b01,
        LD_FULL = 2'b10
    } ld_state_t;

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational encoder from a symbolic request to a 32-bit RV32I instruction word.
module rv_instr_encoder
    import rv_isa_pkg::*;
(
    input  op_kind_t    op_kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word
);

    // Field packing per instruction format; bne drops imm[0] because branch offsets are halfword-aligned.
    always_comb begin
        word = '0;
        case (op_kind)
            OP_ADDI: word = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
            OP_BNE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
            OP_SW:   word = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
            OP_LW:   word = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: accepts symbolic requests, encodes them and writes them at sequential word addresses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// LD_IDLE | no load in progress; waits for start
// LD_LOAD | accepting requests, one registered write per handshake
// LD_FULL | MAX_WORDS written; requests refused until finish or start
module instr_loader
    import rv_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 64,
    localparam int CW = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_kind,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [12:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]         LAST = CW'(MAX_WORDS);

    ld_state_t             state;
    ld_state_t             state_nxt;
    logic                  hs;
    logic                  last;
    logic [CW-1:0]         count_inc;
    logic [31:0]           enc_word;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    // count doubles as the write index: both always move together.
    assign hs        = op_valid && op_ready;
    assign count_inc = count + 1'b1;
    assign last      = (count_inc == LAST);
    assign addr_nxt  = BASE + (ADDR_WIDTH'(count) << 2);
    assign busy      = (state != LD_IDLE);

    rv_instr_encoder u_enc (
        .op_kind (op_kind_t'(op_kind)),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .word    (enc_word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LD_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and op_ready; start outranks finish, finish outranks reaching capacity.
    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        case (state)
            LD_IDLE: begin
                if (start) state_nxt = LD_LOAD;
            end
            LD_LOAD: begin
                op_ready = 1'b1;
                if (start)           state_nxt = LD_LOAD;
                else if (finish)     state_nxt = LD_IDLE;
                else if (hs && last) state_nxt = LD_FULL;
            end
            LD_FULL: begin
                if (start)       state_nxt = LD_LOAD;
                else if (finish) state_nxt = LD_IDLE;
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    // Write port and progress counters; a start restarts counting even when it coincides with a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            mem_we <= hs;
            if (hs) begin
                mem_addr  <= addr_nxt;
                mem_wdata <= enc_word;
            end
            if (start) begin
                count <= '0;
                full  <= 1'b0;
            end else if (hs) begin
                count <= count_inc;
                if (last) full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default build and a MAX_WORDS=4 build share clock and reset.
module tb_instr_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [6:0]  cnt;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op_kind = 2'b00;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [12:0] imm = '0;

    logic        start = 1'b0, finish = 1'b0, op_valid = 1'b0;
    logic        op_ready, mem_we, full, busy;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;

    logic        start4 = 1'b0, finish4 = 1'b0, op_valid4 = 1'b0;
    logic        op_ready4, mem_we4, full4, busy4;
    logic [7:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [2:0]  count4;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    instr_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .busy(busy)
    );

    instr_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .finish(finish4),
        .op_valid(op_valid4), .op_ready(op_ready4), .op_kind(op_kind),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .count(count4), .full(full4), .busy(busy4)
    );

    function automatic logic [31:0] enc_addi(input logic [4:0] d, input logic [4:0] s1, input logic [12:0] im);
        return {im[11:0], s1, 3'b000, d, 7'b0010011};
    endfunction

    // Monitor for the default build: every write must match the oldest expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({mem_addr, mem_wdata, count, full} !== {e.addr, e.data, e.cnt, e.full}) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h count=%0d full=%b want addr=%h data=%h count=%0d full=%b",
                             mem_addr, mem_wdata, count, full, e.addr, e.data, e.cnt, e.full);
                end
            end
        end
    end

    // Monitor for the MAX_WORDS=4 build.
    always @(negedge clk) begin
        if (mem_we4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL write4_unexpected addr=%h data=%h", mem_addr4, mem_wdata4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                if ({mem_addr4, mem_wdata4, {4'b0, count4}, full4} !== {e.addr, e.data, e.cnt, e.full}) begin
                    errors++;
                    $display("FAIL write4 got addr=%h data=%h count=%0d full=%b want addr=%h data=%h count=%0d full=%b",
                             mem_addr4, mem_wdata4, count4, full4, e.addr, e.data, e.cnt, e.full);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [12:0] im, input logic st, input logic fin,
                         input logic [7:0] ea, input logic [31:0] ed, input logic [6:0] ec);
        @(negedge clk);
        op_kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im;
        op_valid = 1'b1; start = st; finish = fin;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready got %b want 1", op_ready);
        end
        q.push_back('{ea, ed, ec, 1'b0});
    endtask

    task automatic idle();
        @(negedge clk);
        op_valid = 1'b0; start = 1'b0; finish = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, count, full, busy, op_ready} !== {1'b0, 8'h00, 32'h0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s got we=%b addr=%h data=%h count=%0d full=%b busy=%b ready=%b want all zero",
                     tag, mem_we, mem_addr, mem_wdata, count, full, busy, op_ready);
        end
        checks++;
        if ({mem_we4, mem_addr4, mem_wdata4, count4, full4, busy4, op_ready4} !== {1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_small got we=%b addr=%h data=%h count=%0d full=%b busy=%b ready=%b want all zero",
                     tag, mem_we4, mem_addr4, mem_wdata4, count4, full4, busy4, op_ready4);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_single();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_load got busy=%b ready=%b want 1 1", busy, op_ready);
        end
        issue(2'b00, 5'd1, 5'd0, 5'd0, 13'h00FF, 1'b0, 1'b0, 8'h00, 32'h0FF00093, 7'd1);
        idle();
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 5'd0, 5'd1, 5'd0, 13'h1FFC, 1'b0, 1'b0, 8'h04, 32'hFE009EE3, 7'd2);
        issue(2'b10, 5'd0, 5'd0, 5'd2, 13'd8,    1'b0, 1'b0, 8'h08, 32'h00202423, 7'd3);
        issue(2'b11, 5'd3, 5'd0, 5'd0, 13'd8,    1'b0, 1'b0, 8'h0C, 32'h00802183, 7'd4);
        idle();
        checks++;
        if (count !== 7'd4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", count);
        end
    endtask

    task automatic test_start_collision();
        issue(2'b00, 5'd4, 5'd2, 5'd0, 13'd4, 1'b0, 1'b0, 8'h10, enc_addi(5'd4, 5'd2, 13'd4), 7'd5);
        issue(2'b00, 5'd5, 5'd2, 5'd0, 13'd5, 1'b1, 1'b1, 8'h14, enc_addi(5'd5, 5'd2, 13'd5), 7'd0);
        issue(2'b00, 5'd6, 5'd2, 5'd0, 13'h0800, 1'b0, 1'b0, 8'h00, enc_addi(5'd6, 5'd2, 13'h0800), 7'd1);
        idle();
    endtask

    task automatic test_finish_collision();
        issue(2'b00, 5'd7, 5'd3, 5'd0, 13'h1FFF, 1'b0, 1'b1, 8'h04, enc_addi(5'd7, 5'd3, 13'h1FFF), 7'd2);
        idle();
        checks++;
        if (busy !== 1'b0 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL finish_idle got busy=%b ready=%b want 0 0", busy, op_ready);
        end
        op_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got %b want 0", op_ready);
        end
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL finish_pending got %0d want 0", q.size());
        end
    endtask

    task automatic test_full();
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op_kind = 2'b00; rd = 5'(i + 1); rs1 = 5'd1; imm = 13'(i + 16);
            op_valid4 = 1'b1;
            checks++;
            if (op_ready4 !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready[%0d] got %b want %b", i, op_ready4, (i < 4));
            end
            if (i < 4)
                q4.push_back('{8'(i * 4), enc_addi(5'(i + 1), 5'd1, 13'(i + 16)), 7'(i + 1), (i == 3)});
        end
        @(negedge clk);
        op_valid4 = 1'b0;
        checks++;
        if ({op_ready4, full4, busy4, count4} !== {1'b0, 1'b1, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL full_hold got ready=%b full=%b busy=%b count=%0d want 0 1 1 4", op_ready4, full4, busy4, count4);
        end
        finish4 = 1'b1;
        @(negedge clk);
        finish4 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || full4 !== 1'b1) begin
            errors++;
            $display("FAIL full_finish got busy=%b full=%b want 0 1", busy4, full4);
        end
        checks++;
        if (q4.size() != 0) begin
            errors++;
            $display("FAIL full_pending got %0d want 0", q4.size());
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        issue(2'b10, 5'd0, 5'd4, 5'd9, 13'h0FFF, 1'b0, 1'b0, 8'h00, 32'hFE922FA3, 7'd1);
        @(posedge clk);
        #2;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_we got %b want 1", mem_we);
        end
        q.delete();
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("arst_released");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_start_collision();
        test_finish_collision();
        test_full();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
